// File: rtl/fifo_rd_gearbox_pkg.sv
// Shared definitions for the FIFO read-side gearbox.
//   gb_state_t : FSM encoding (FILL accumulates lanes, HOLD parks a closed beat)
//   cnt_w()    : lane-counter width for a given lane ratio
package fifo_rd_gearbox_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } gb_state_t;

  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready output register: loads a payload, holds it stable while the
// consumer stalls, and drops valid on accept when nothing new loads.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load, load_data   : load a new payload (only asserted when free=1)
//   out_ready         : consumer ready
//   out_valid/out_data: registered stream output
//   free              : register can take a payload at this edge
module stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_gearbox.sv
// Read-side width converter: pops DATA_SIZE-bit words from a FIFO and packs
// RATIO of them into one beat on a valid/ready stream. flush closes a partial
// beat (marked last, lane mask in out_keep).
// Ports:
//   rd_clk, rd_rst          : clock, synchronous active-high reset
//   fifo_empty/fifo_rd_data : FIFO read port, fifo_rd_en pops at the edge
//   flush                   : close the current partial beat
//   out_valid/out_ready     : output handshake
//   out_data/out_keep/out_last : beat payload, lane 0 = first-popped word
module fifo_rd_gearbox
  import fifo_rd_gearbox_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int RATIO     = 4
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      fifo_empty,
  input  logic [DATA_SIZE-1:0]      fifo_rd_data,
  output logic                      fifo_rd_en,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_SIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic                      out_last
);

  localparam int CNT_W = cnt_w(RATIO);
  localparam int OW    = DATA_SIZE * RATIO;
  localparam int PW    = OW + RATIO + 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  gb_state_t                         state, state_nxt;
  logic [RATIO-1:0][DATA_SIZE-1:0]   acc, acc_nxt, beat_data;
  logic [RATIO-1:0]                  acc_keep, keep_nxt, beat_keep;
  logic                              acc_last, last_nxt, beat_last;
  logic [CNT_W-1:0]                  cnt, cnt_nxt;
  logic                              pop, full_close, flush_close;
  logic                              load, free;
  logic [PW-1:0]                     out_payload;

  // Pop strobe depends only on state, empty and reset: no ready/flush path.
  assign fifo_rd_en = (state == FILL) && !fifo_empty && !rd_rst;
  assign pop        = fifo_rd_en;

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    keep_nxt    = acc_keep;
    last_nxt    = acc_last;
    cnt_nxt     = cnt;
    load        = 1'b0;
    full_close  = 1'b0;
    flush_close = 1'b0;
    beat_data   = acc;
    beat_keep   = acc_keep;
    beat_last   = acc_last;
    case (state)
      FILL: begin
        // beat_* is the accumulator with this cycle's pop merged in.
        if (pop) begin
          beat_data[cnt] = fifo_rd_data;
          beat_keep[cnt] = 1'b1;
        end
        full_close  = pop && (cnt == LAST_LANE);
        flush_close = flush && ((cnt != '0) || pop);
        if (flush_close) beat_last = 1'b1;
        if (full_close || flush_close) begin
          cnt_nxt = '0;
          if (free) begin
            load     = 1'b1;
            acc_nxt  = '0;
            keep_nxt = '0;
            last_nxt = 1'b0;
          end else begin
            acc_nxt   = beat_data;
            keep_nxt  = beat_keep;
            last_nxt  = beat_last;
            state_nxt = HOLD;
          end
        end else if (pop) begin
          acc_nxt  = beat_data;
          keep_nxt = beat_keep;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // A flush arriving on the exit cycle still marks the held beat last.
        if (flush) beat_last = 1'b1;
        if (free) begin
          load      = 1'b1;
          acc_nxt   = '0;
          keep_nxt  = '0;
          last_nxt  = 1'b0;
          state_nxt = FILL;
        end else begin
          last_nxt = beat_last;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state    <= FILL;
      acc      <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      acc_keep <= keep_nxt;
      acc_last <= last_nxt;
      cnt      <= cnt_nxt;
    end
  end

  stream_out_reg #(.W(PW)) u_out (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .load      (load),
    .load_data ({beat_last, beat_keep, beat_data}),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_payload),
    .free      (free)
  );

  assign out_data = out_payload[OW-1:0];
  assign out_keep = out_payload[OW+RATIO-1:OW];
  assign out_last = out_payload[PW-1];

endmodule

// File: doc/fifo_rd_gearbox.md
# fifo_rd_gearbox

Read-side width converter in the `rd_clk` domain, directly downstream of the async FIFO's read port. It pops `DATA_SIZE`-bit words from the FIFO whenever `empty` is low and packs `RATIO` consecutive words into one wide output beat. The beat is presented on a valid/ready stream. A `flush` input closes a partially filled beat and marks it last, using a lane mask.

## Interface
- `DATA_SIZE`, 8: width of one FIFO word (one lane).
- `RATIO`, 4: lanes per output beat; power of two, ≥2. Output width is `DATA_SIZE*RATIO`.
- `rd_clk` in 1: single clock; all state updates on the rising edge.
- `rd_rst` in 1: synchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_data` in `DATA_SIZE`: FIFO head word. Valid whenever `fifo_empty`=0.
- `fifo_rd_en` out 1: pop strobe. The FIFO advances at the edge where this is high.
- `flush` in 1: single-cycle request to close the current partial beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: consumer accepts the beat at the edge where `out_valid`&&`out_ready`.
- `out_data` out `DATA_SIZE*RATIO`: packed beat. Lane 0 is bits `[DATA_SIZE-1:0]` and holds the first-popped word.
- `out_keep` out `RATIO`: lane-valid mask; bit i set means lane i holds data.
- `out_last` out 1: beat was closed by `flush`.

## Operation
- **Datapath state:**
  - Accumulator `acc` (`RATIO` lanes).
  - Lane counter `cnt` (0..RATIO-1, width log2(RATIO)).
  - Accumulator flags `acc_keep` and `acc_last`.
  - One output register holding `out_*`.
- **FSM states:**
  - FILL: accumulating. `fifo_rd_en` = !`fifo_empty` && !`rd_rst`.
  - HOLD: a complete or closed beat sits in `acc` waiting for the output register. `fifo_rd_en`=0.
- **Pop in FILL:** `acc` lane `cnt` takes `fifo_rd_data`, the matching `acc_keep` bit is set, and `cnt` increments.
- **Beat close:** a beat closes in FILL on either event:
  - a pop into lane RATIO-1;
  - `flush`=1 with (`cnt`>0 or a pop in the same cycle). In this case `last`=1, and a same-cycle pop is included in the beat.
- **On close:**
  - If the output register is free this edge (`out_valid`=0, or `out_ready`=1), the beat loads directly into `out_*`. The FSM stays in FILL with `cnt`=0 and `acc`/`acc_keep` cleared.
  - Otherwise the beat goes to HOLD.
- **Unused lanes** of a partial beat are zero in `out_data`.
- **HOLD exit:** when the output register frees, `acc` transfers to `out_*`, `acc` is cleared, and the FSM returns to FILL.
- **`flush` in HOLD:** sets `acc_last`; the held beat emits with `out_last`=1.
- **`flush` in FILL** with `cnt`=0 and no pop: ignored. No empty beat is ever produced.
- **Output register** is cleared of valid on handshake when nothing loads.
- **Stability:** `out_data`/`out_keep`/`out_last` are stable while `out_valid`&&!`out_ready`.
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0.
  - `fifo_rd_en`=0 while `rd_rst`=1.
  - `cnt`=0, `acc`=0, FSM in FILL.
  - Reset mid-beat discards partial data; no beat is emitted for it.

## Timing
- `fifo_rd_en` is combinational from `fifo_empty`, FSM state and `rd_rst` only. There is no path from `out_ready` or `flush`.
- Latency: the pop closing a beat at edge N gives `out_valid`=1 after edge N (if the output register is free).
- Throughput: one FIFO word per cycle while the FIFO is non-empty and the consumer keeps up. A beat emits every RATIO cycles.
- A HOLD→FILL transition costs exactly one cycle with no pop.
- Under backpressure: at most 2·RATIO words are popped beyond the last accepted beat (one output beat plus one held), then popping stops.

## Structure
- Shared package/header: FSM state encodings (FILL, HOLD), and `CNT_W` = clog2(RATIO) helper.
- One natural sub-module, `stream_out_reg`: the valid/ready output register (load, hold, clear-on-accept), parameterised by payload width.

## Test plan
- **Full beat:** RATIO=4, `out_ready`=1, words 0x11,0x22,0x33,0x44 → one beat, `out_data`=0x44332211, `out_keep`=4'b1111, `out_last`=0, `out_valid` high the cycle after the 4th pop.
- **Partial flush:** pop 0xA0,0xA1,0xA2, then `flush` with FIFO empty → `out_data`=0x00A2A1A0, `out_keep`=4'b0111, `out_last`=1.
- **Flush corner cases:**
  - `flush` coincident with the 4th pop → `out_keep`=4'b1111, `out_last`=1.
  - `flush` with `cnt`=0 and no pop → no beat.
- **Backpressure:** `out_ready`=0 with 12 words available → exactly 8 pops, then `fifo_rd_en` stays 0 and `out_data` is stable. Release `out_ready` → beats emit in order, and the remaining 4 words form a third beat.
- **Reset mid-beat:** 2 pops, then `rd_rst` for one cycle → all outputs 0 and no partial beat emitted. The next 4 words 0x01..0x04 give `out_data`=0x04030201.
- **Bursty source:** `fifo_empty` toggling every cycle → `fifo_rd_en` is never high while empty, and beats are correct and in order.
